// File: rtl/ddr_burst_responder_if.sv
// Purpose : bundles the DDR burst handshake between the frame arbiter and the burst responder.
// Latency : none, wires only.
// Backpressure: none in the bundle itself; the responder paces bursts with req/valid and state_ready.
// Ports   : master = arbiter side (drives requests and write data),
//           slave  = responder side (drives req/valid/finish/status and read data).
interface ddr_burst_responder_if;
  logic        mem_wen;
  logic        mem_ren;
  logic [24:0] wr_addr;
  logic [24:0] rd_addr;
  logic [9:0]  wr_burst_len;
  logic [31:0] wr_burst_data;
  logic        wr_burst_data_req;
  logic        wr_burst_finish;
  logic [31:0] rd_burst_data;
  logic        rd_burst_data_valid;
  logic        rd_burst_finish;
  logic        ready;
  logic        state_ready;
  logic        err_drop;

  modport master (
    output mem_wen, mem_ren, wr_addr, rd_addr, wr_burst_len, wr_burst_data,
    input  wr_burst_data_req, wr_burst_finish, rd_burst_data, rd_burst_data_valid,
           rd_burst_finish, ready, state_ready, err_drop
  );

  modport slave (
    input  mem_wen, mem_ren, wr_addr, rd_addr, wr_burst_len, wr_burst_data,
    output wr_burst_data_req, wr_burst_finish, rd_burst_data, rd_burst_data_valid,
           rd_burst_finish, ready, state_ready, err_drop
  );
endinterface

// File: rtl/ddr_burst_responder.sv
// Purpose : memory-side DDR burst responder backed by an on-chip RAM, standing in for the DDR controller.
// Latency : write finish at T+len+2, read data from T+RD_LATENCY, read finish at T+RD_LATENCY+len.
// Backpressure: none on data; requests are only taken while state_ready is high, others are dropped (err_drop).
// Ports   : DDR_CLK clock, DDR_RST synchronous active-high reset,
//           bus (slave) = mem_wen/mem_ren requests, addresses, length, write data in;
//           req/valid/finish pulses, read data, ready, state_ready, err_drop out.
module ddr_burst_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int RD_LATENCY  = 2,
  parameter int INIT_CYCLES = 16
) (
  input logic                  DDR_CLK,
  input logic                  DDR_RST,
  ddr_burst_responder_if.slave bus
);

  localparam int         AW        = DEPTH_LOG2;
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [9:0] INIT_LAST = 10'(INIT_CYCLES - 1);
  // Only meaningful when RD_LATENCY > 1; RD_LAT is skipped otherwise.
  localparam logic [9:0] LAT_LAST  = 10'(RD_LATENCY - 2);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_TAIL,
    ST_WR_DONE,
    ST_RD_LAT,
    ST_RD_DATA,
    ST_RD_DONE
  } state_t;

  state_t          state, next_state;
  logic [9:0]      cnt, cnt_nxt;     // init, latency and burst counter (shared, never overlapping)
  logic [9:0]      len_q;
  logic [AW-1:0]   ptr;              // current RAM word address of the burst
  logic            wr_pend;          // a write word is on wr_burst_data this cycle
  logic            accept_wr, accept_rd;
  logic            rd_issue;
  logic [AW-1:0]   issue_addr;

  logic            wr_req_q, wr_fin_q, rd_vld_q, rd_fin_q;
  logic            ready_q, state_rdy_q, err_q;
  logic [31:0]     rd_dat_q;

  logic [31:0]     mem [DEPTH];

  // Upper address bits (bank and beyond) alias onto the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.wr_addr[24:AW], bus.rd_addr[24:AW]};

  always_ff @(posedge DDR_CLK) begin
    if (DDR_RST) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    case (state)
      ST_INIT: begin
        if (cnt == INIT_LAST) begin
          next_state = ST_IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      ST_IDLE: begin
        // Write wins a simultaneous request.
        if (bus.mem_wen) begin
          accept_wr  = 1'b1;
          cnt_nxt    = '0;
          next_state = (bus.wr_burst_len == 10'd0) ? ST_WR_TAIL : ST_WR_REQ;
        end else if (bus.mem_ren) begin
          accept_rd = 1'b1;
          cnt_nxt   = '0;
          if (RD_LATENCY > 1)
            next_state = ST_RD_LAT;
          else
            next_state = (bus.wr_burst_len == 10'd0) ? ST_RD_DONE : ST_RD_DATA;
        end
      end
      ST_WR_REQ: begin
        if (cnt == len_q - 10'd1) begin
          next_state = ST_WR_TAIL;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      ST_WR_TAIL: next_state = ST_WR_DONE;
      ST_WR_DONE: next_state = ST_IDLE;
      ST_RD_LAT: begin
        if (cnt == LAT_LAST) begin
          cnt_nxt    = '0;
          next_state = (len_q == 10'd0) ? ST_RD_DONE : ST_RD_DATA;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      ST_RD_DATA: begin
        if (cnt == len_q - 10'd1) begin
          next_state = ST_RD_DONE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      ST_RD_DONE: next_state = ST_IDLE;
      default:    next_state = ST_INIT;
    endcase
  end

  // The RAM read for a valid cycle is issued one cycle earlier so the data
  // register lines up with rd_burst_data_valid. With RD_LATENCY == 1 the first
  // read is issued in the accept cycle straight from rd_addr.
  assign rd_issue   = (next_state == ST_RD_DATA);
  assign issue_addr = accept_rd ? bus.rd_addr[AW-1:0] : ptr;

  always_ff @(posedge DDR_CLK) begin
    if (DDR_RST) begin
      len_q       <= '0;
      ptr         <= '0;
      wr_pend     <= 1'b0;
      wr_req_q    <= 1'b0;
      wr_fin_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_fin_q    <= 1'b0;
      rd_dat_q    <= '0;
      ready_q     <= 1'b0;
      state_rdy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept_wr || accept_rd)
        len_q <= bus.wr_burst_len;

      // Write data trails its request by one cycle.
      wr_pend <= (state == ST_WR_REQ);

      // ptr arithmetic wraps at the top of RAM by width.
      if (accept_wr)
        ptr <= bus.wr_addr[AW-1:0];
      else if (rd_issue)
        ptr <= issue_addr + AW'(1);
      else if (accept_rd)
        ptr <= bus.rd_addr[AW-1:0];
      else if (wr_pend)
        ptr <= ptr + AW'(1);

      if (rd_issue)
        rd_dat_q <= mem[issue_addr];

      wr_req_q    <= (next_state == ST_WR_REQ);
      wr_fin_q    <= (next_state == ST_WR_DONE);
      rd_vld_q    <= rd_issue;
      rd_fin_q    <= (next_state == ST_RD_DONE);
      state_rdy_q <= (next_state == ST_IDLE);
      if (next_state == ST_IDLE)
        ready_q <= 1'b1;

      if (((bus.mem_wen || bus.mem_ren) && state != ST_IDLE) ||
          (state == ST_IDLE && bus.mem_wen && bus.mem_ren))
        err_q <= 1'b1;
    end
  end

  // RAM contents survive reset; a write in the reset cycle is suppressed.
  always_ff @(posedge DDR_CLK) begin
    if (!DDR_RST && wr_pend)
      mem[ptr] <= bus.wr_burst_data;
  end

  assign bus.wr_burst_data_req   = wr_req_q;
  assign bus.wr_burst_finish     = wr_fin_q;
  assign bus.rd_burst_data       = rd_dat_q;
  assign bus.rd_burst_data_valid = rd_vld_q;
  assign bus.rd_burst_finish     = rd_fin_q;
  assign bus.ready               = ready_q;
  assign bus.state_ready         = state_rdy_q;
  assign bus.err_drop            = err_q;

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Purpose : self-checking bench for ddr_burst_responder against a word-array memory model.
// Latency : checks finish/valid cycle positions relative to the accept cycle.
// Backpressure: bench supplies write data one cycle after each request.
module tb_ddr_burst_responder;
  localparam int RL     = 2;
  localparam int INIT_N = 16;
  localparam int DEPTH  = 4096;

  logic DDR_CLK = 1'b0;
  logic DDR_RST;
  ddr_burst_responder_if bus();

  ddr_burst_responder #(.DEPTH_LOG2(12), .RD_LATENCY(RL), .INIT_CYCLES(INIT_N)) dut (
    .DDR_CLK (DDR_CLK),
    .DDR_RST (DDR_RST),
    .bus     (bus)
  );

  always #5 DDR_CLK = ~DDR_CLK;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  bit          exp_err;
  logic [31:0] wq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Each bench cycle runs negedge to negedge: outputs are stable, inputs set
  // here are sampled at the following posedge.
  task automatic next_cycle();
    @(negedge DDR_CLK);
    cyc++;
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({bus.wr_burst_data_req, bus.wr_burst_finish, bus.rd_burst_data_valid,
                bus.rd_burst_finish, bus.ready, bus.state_ready, bus.err_drop});
  endfunction

  task automatic reset_init(input int hold);
    DDR_RST = 1'b1;
    repeat (hold) next_cycle();
    chk("rst_outputs_zero", outs_vec(), 0);
    chk("rst_rd_data_zero", bus.rd_burst_data, 0);
    DDR_RST = 1'b0;
    exp_err = 1'b0;
    for (int i = 1; i <= INIT_N; i++) begin
      next_cycle();
      chk("init_ready", 32'(bus.ready), 32'(i == INIT_N));
      chk("init_state_ready", 32'(bus.state_ready), 32'(i == INIT_N));
    end
    chk("init_other_outputs_zero", 32'({bus.wr_burst_data_req, bus.wr_burst_finish,
        bus.rd_burst_data_valid, bus.rd_burst_finish, bus.err_drop}), 0);
  endtask

  task automatic model_store(input logic [24:0] addr, input int n);
    logic [11:0] a;
    for (int k = 0; k < n; k++) begin
      a = 12'(addr[11:0] + 12'(k));
      model_mem[a] = wq[k];
      known[a]     = 1'b1;
    end
  endtask

  task automatic do_write(input logic [24:0] addr, input int len, input bit with_ren, input int ren_at);
    int t0, nreq, nvld, fin_cyc, first_req, idx;
    bit prev_req;
    chk("wr_start_state_ready", 32'(bus.state_ready), 1);
    t0 = cyc; nreq = 0; nvld = 0; fin_cyc = -1; first_req = -1; idx = 0; prev_req = 1'b0;
    bus.mem_wen = 1'b1; bus.mem_ren = with_ren; bus.wr_addr = addr;
    bus.rd_addr = 25'($urandom); bus.wr_burst_len = 10'(len);
    if (with_ren) exp_err = 1'b1;
    for (int i = 0; i < len + 20 && fin_cyc < 0; i++) begin
      next_cycle();
      bus.mem_wen = 1'b0;
      bus.mem_ren = (i == ren_at);
      if (i == ren_at) exp_err = 1'b1;
      bus.wr_burst_len = 10'($urandom);
      if (prev_req && idx < wq.size()) begin
        bus.wr_burst_data = wq[idx];
        idx++;
      end else begin
        bus.wr_burst_data = $urandom;
      end
      prev_req = bus.wr_burst_data_req;
      if (bus.wr_burst_data_req) begin
        nreq++;
        if (first_req < 0) first_req = cyc;
      end
      if (bus.rd_burst_data_valid) nvld++;
      if (bus.wr_burst_finish) fin_cyc = cyc;
    end
    bus.mem_ren = 1'b0;
    chk("wr_req_count", nreq, len);
    chk("wr_finish_cycle", fin_cyc, t0 + len + 2);
    chk("wr_no_rd_valid", nvld, 0);
    if (len > 0) chk("wr_first_req", first_req, t0 + 1);
    next_cycle();
    chk("wr_end_state_ready", 32'(bus.state_ready), 1);
    chk("wr_err_drop", 32'(bus.err_drop), 32'(exp_err));
    model_store(addr, len);
  endtask

  task automatic do_read(input logic [24:0] addr, input int len);
    int t0, nvld, nreq, fin_cyc, first_vld, last_vld, gaps;
    logic [11:0] a;
    chk("rd_start_state_ready", 32'(bus.state_ready), 1);
    t0 = cyc; nvld = 0; nreq = 0; fin_cyc = -1; first_vld = -1; last_vld = -1; gaps = 0;
    bus.mem_ren = 1'b1; bus.rd_addr = addr; bus.wr_addr = 25'($urandom);
    bus.wr_burst_len = 10'(len);
    for (int i = 0; i < len + RL + 20 && fin_cyc < 0; i++) begin
      next_cycle();
      bus.mem_ren = 1'b0;
      bus.wr_burst_len = 10'($urandom);
      bus.wr_burst_data = $urandom;
      if (bus.wr_burst_data_req) nreq++;
      if (bus.rd_burst_data_valid) begin
        if (first_vld < 0) first_vld = cyc;
        else if (cyc != last_vld + 1) gaps++;
        last_vld = cyc;
        a = 12'(addr[11:0] + 12'(nvld));
        if (known[a]) chk("rd_data", bus.rd_burst_data, model_mem[a]);
        nvld++;
      end
      if (bus.rd_burst_finish) fin_cyc = cyc;
    end
    chk("rd_valid_count", nvld, len);
    chk("rd_finish_cycle", fin_cyc, t0 + RL + len);
    chk("rd_no_gaps", gaps, 0);
    chk("rd_no_wr_req", nreq, 0);
    if (len > 0) chk("rd_first_valid", first_vld, t0 + RL);
    next_cycle();
    chk("rd_end_state_ready", 32'(bus.state_ready), 1);
    chk("rd_err_drop", 32'(bus.err_drop), 32'(exp_err));
  endtask

  task automatic do_write_abort(input logic [24:0] addr, input int len, input int abort_word);
    int idx, nfin;
    bit prev_req, aborted;
    logic [11:0] a;
    chk("abort_start_state_ready", 32'(bus.state_ready), 1);
    idx = 0; nfin = 0; prev_req = 1'b0; aborted = 1'b0;
    bus.mem_wen = 1'b1; bus.wr_addr = addr; bus.wr_burst_len = 10'(len);
    for (int i = 0; i < len + 20 && !aborted; i++) begin
      next_cycle();
      bus.mem_wen = 1'b0;
      bus.wr_burst_len = 10'($urandom);
      if (bus.wr_burst_finish) nfin++;
      if (idx == abort_word) begin
        DDR_RST = 1'b1;
        aborted = 1'b1;
      end else begin
        if (prev_req && idx < wq.size()) begin
          bus.wr_burst_data = wq[idx];
          idx++;
        end
        prev_req = bus.wr_burst_data_req;
      end
    end
    chk("abort_reached", 32'(aborted), 1);
    model_store(addr, abort_word);
    for (int k = abort_word; k < len; k++) begin
      a = 12'(addr[11:0] + 12'(k));
      known[a] = 1'b0;
    end
    next_cycle();
    chk("abort_outputs_cleared", outs_vec(), 0);
    DDR_RST = 1'b0;
    exp_err = 1'b0;
    for (int i = 1; i <= INIT_N; i++) begin
      next_cycle();
      if (bus.wr_burst_finish) nfin++;
      chk("abort_init_state_ready", 32'(bus.state_ready), 32'(i == INIT_N));
    end
    chk("abort_no_finish", nfin, 0);
  endtask

  initial begin
    logic [24:0] ra;
    int          rl;
    DDR_RST = 1'b1;
    bus.mem_wen = 1'b0; bus.mem_ren = 1'b0; bus.wr_addr = '0; bus.rd_addr = '0;
    bus.wr_burst_len = '0; bus.wr_burst_data = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Reset and calibration delay.
    reset_init(3);

    // Ordered 256-word write then read back.
    wq.delete();
    for (int k = 0; k < 256; k++) wq.push_back(32'h1000 + 32'(k));
    do_write(25'd0, 256, 1'b0, -1);
    do_read(25'd0, 256);

    // Wrap at the top of RAM.
    wq.delete();
    for (int k = 0; k < 8; k++) wq.push_back($urandom);
    do_write(25'd4092, 8, 1'b0, -1);
    do_read(25'd4092, 8);
    do_read(25'd0, 4);

    // Bank/upper-bit aliasing.
    wq.delete();
    for (int k = 0; k < 16; k++) wq.push_back($urandom);
    do_write(25'h0800000, 16, 1'b0, -1);
    do_read(25'h0000000, 16);

    // Zero-length bursts.
    wq.delete();
    do_write(25'd77, 0, 1'b0, -1);
    do_read(25'd77, 0);

    // Randomized bursts, read back through random alias bits.
    for (int n = 0; n < 6; n++) begin
      ra = 25'($urandom);
      rl = $urandom_range(0, 40);
      wq.delete();
      for (int k = 0; k < rl; k++) wq.push_back($urandom);
      do_write(ra, rl, 1'b0, -1);
      do_read({13'($urandom), ra[11:0]}, rl);
    end

    // Reset in the middle of a write burst.
    wq.delete();
    for (int k = 0; k < 256; k++) wq.push_back($urandom);
    do_write_abort(25'd0, 256, 100);
    chk("abort_err_cleared", 32'(bus.err_drop), 0);
    do_read(25'd0, 256);

    // Read request during a write burst is dropped.
    wq.delete();
    for (int k = 0; k < 10; k++) wq.push_back($urandom);
    do_write(25'd500, 10, 1'b0, 3);
    do_read(25'd500, 10);

    // Simultaneous write and read: write runs, read dropped.
    reset_init(2);
    chk("collision_err_before", 32'(bus.err_drop), 0);
    wq.delete();
    for (int k = 0; k < 4; k++) wq.push_back($urandom);
    do_write(25'd1000, 4, 1'b1, -1);
    do_read(25'd1000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
